// File: rtl/poly_ctrl.sv
// Sequencing controller for a Horner-style polynomial datapath (A*X+B or A*X^2+B*X+C).
// Optional abort input enabled by defining POLY_CTRL_ABORT_EN.
module poly_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       deg,
`ifdef POLY_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy,
  output logic       done,
  output logic       LX,
  output logic       LH,
  output logic       LS,
  output logic       H,
  output logic [1:0] M0,
  output logic [1:0] M1,
  output logic [1:0] M2,
  output logic [7:0] op_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOADX = 3'd1,
    MUL1  = 3'd2,
    ADD1  = 3'd3,
    MUL2  = 3'd4,
    ADD2  = 3'd5,
    DONE  = 3'd6
  } state_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       lx;
    logic       ls;
    logic       h;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
  } ctrl_t;

  state_t state;
  state_t nxt;
  ctrl_t  ctrl;
  logic   deg_q;
  logic   abort_req;

`ifdef POLY_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Outputs are a pure function of the state being entered, so registering
  // decode(nxt) keeps them aligned with the state register (Moore behaviour).
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      LOADX: begin c.busy = 1'b1; c.lx = 1'b1; end
      MUL1:  begin c.busy = 1'b1; c.h = 1'b1; c.ls = 1'b1; end
      ADD1:  begin c.busy = 1'b1; c.m0 = 2'b01; c.m2 = 2'b10; c.ls = 1'b1; end
      MUL2:  begin c.busy = 1'b1; c.m1 = 2'b01; c.m2 = 2'b10; c.h = 1'b1; c.ls = 1'b1; end
      ADD2:  begin c.busy = 1'b1; c.m0 = 2'b10; c.m2 = 2'b10; c.ls = 1'b1; end
      DONE:  begin c.busy = 1'b1; c.done = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = (start && !abort_req) ? LOADX : IDLE;
      LOADX:   nxt = MUL1;
      MUL1:    nxt = ADD1;
      ADD1:    nxt = deg_q ? MUL2 : DONE;
      MUL2:    nxt = ADD2;
      ADD2:    nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (state != IDLE && abort_req) nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ctrl   <= '0;
      deg_q  <= 1'b0;
      op_cnt <= 8'd0;
    end else begin
      state <= nxt;
      ctrl  <= decode(nxt);
      if (state == IDLE && start && !abort_req) deg_q <= deg;
      if (nxt == DONE) op_cnt <= op_cnt + 8'd1;
    end
  end

  assign busy = ctrl.busy;
  assign done = ctrl.done;
  assign LX   = ctrl.lx;
  assign LH   = 1'b0;
  assign LS   = ctrl.ls;
  assign H    = ctrl.h;
  assign M0   = ctrl.m0;
  assign M1   = ctrl.m1;
  assign M2   = ctrl.m2;

endmodule

// File: tb/tb_poly_ctrl.sv
// Bench for poly_ctrl: a behavioural datapath follows the control outputs and
// completed evaluations are scored against an expected-result queue.
module tb_poly_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       deg;
`ifdef POLY_CTRL_ABORT_EN
  logic       abort;
`endif
  logic       busy, done, LX, LH, LS, H;
  logic [1:0] M0, M1, M2;
  logic [7:0] op_cnt;

  always #5 clk = ~clk;

  poly_ctrl dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .deg(deg),
`ifdef POLY_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy),
    .done(done),
    .LX(LX),
    .LH(LH),
    .LS(LS),
    .H(H),
    .M0(M0),
    .M1(M1),
    .M2(M2),
    .op_cnt(op_cnt)
  );

  typedef struct packed {
    int         res;
    int         cyc;
    logic [7:0] cnt;
    int         muls;
    logic       done2;
  } obs_t;

  typedef struct packed {
    int         res;
    int         cyc;
    logic [7:0] cnt;
    int         muls;
  } exp_t;

  obs_t obs_q[$];
  exp_t exp_q[$];

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_cnt = 8'd0;

  // Behavioural datapath driven by the controller
  int a_in = 0, b_in = 0, c_in = 0, x_in = 0;
  int x_r = 0, s_r = 0, m0v, op1, op2, alu;
  int mul_cnt = 0;
  int cyc = 0;

  always_comb begin
    m0v = 0;
    op1 = 0;
    op2 = 0;
    case (M0)
      2'b00: m0v = a_in;
      2'b01: m0v = b_in;
      2'b10: m0v = c_in;
      default: m0v = 0;
    endcase
    case (M1)
      2'b00: op1 = m0v;
      2'b01: op1 = x_r;
      default: op1 = 0;
    endcase
    case (M2)
      2'b00: op2 = x_r;
      2'b10: op2 = s_r;
      default: op2 = 0;
    endcase
    alu = H ? op1 * op2 : op1 + op2;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (LX) x_r <= x_in;
    if (LS) s_r <= alu;
    if (LX) mul_cnt <= 0;
    else if (H) mul_cnt <= mul_cnt + 1;
  end

  // Record each done pulse one cycle later, together with the follow-up cycle
  logic done_seen = 1'b0;
  int   res_hold = 0, cyc_hold = 0, mul_hold = 0;

  always @(negedge clk) begin
    if (done_seen) obs_q.push_back({res_hold, cyc_hold, op_cnt, mul_hold, done});
    done_seen <= done;
    if (done) begin
      res_hold <= s_r;
      cyc_hold <= cyc;
      mul_hold <= mul_cnt;
    end
  end

  task automatic get_obs(input int limit, output obs_t o, output bit ok);
    int n;
    n = 0;
    while (obs_q.size() == 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    ok = (obs_q.size() != 0);
    if (ok) o = obs_q.pop_front();
    else o = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; deg = 1'b0;
`ifdef POLY_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b expected 0", done); end
    n_cmp++; if ({LX, LH, LS, H} !== 4'b0) begin n_err++; $display("FAIL rst_enables: got %b expected 0000", {LX, LH, LS, H}); end
    n_cmp++; if ({M0, M1, M2} !== 6'b0) begin n_err++; $display("FAIL rst_mux: got %b expected 000000", {M0, M1, M2}); end
    n_cmp++; if (op_cnt !== 8'd0) begin n_err++; $display("FAIL rst_op_cnt: got %0d expected 0", op_cnt); end
    start = 1'b0;
  endtask

  task automatic test_quadratic();
    obs_t o; exp_t e; bit ok; int samp;
    @(negedge clk);
    x_in = 2; a_in = 3; b_in = 4; c_in = 5; deg = 1'b1; start = 1'b1; rst = 1'b1;
    @(negedge clk);
    samp = cyc; start = 1'b0;
    n_cmp++; if ({busy, LX} !== 2'b11) begin n_err++; $display("FAIL quad_first_edge: got busy,LX=%b expected 11", {busy, LX}); end
    exp_cnt = exp_cnt + 8'd1;
    exp_q.push_back({32'sd25, samp + 5, exp_cnt, 32'sd2});
    get_obs(30, o, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL quad_done: got none expected one done pulse"); end
    else begin
      if (o.res !== e.res) begin n_err++; $display("FAIL quad_result: got %0d expected %0d", o.res, e.res); end
      n_cmp++; if (o.cyc !== e.cyc) begin n_err++; $display("FAIL quad_latency: got %0d expected %0d", o.cyc - samp, e.cyc - samp); end
      n_cmp++; if (o.cnt !== e.cnt) begin n_err++; $display("FAIL quad_op_cnt: got %0d expected %0d", o.cnt, e.cnt); end
      n_cmp++; if (o.muls !== e.muls) begin n_err++; $display("FAIL quad_muls: got %0d expected %0d", o.muls, e.muls); end
      n_cmp++; if (o.done2 !== 1'b0) begin n_err++; $display("FAIL quad_pulse: got %b expected 0", o.done2); end
    end
  endtask

  task automatic test_linear();
    obs_t o; exp_t e; bit ok; int samp;
    @(negedge clk);
    x_in = 7; a_in = 2; b_in = 9; c_in = 100; deg = 1'b0; start = 1'b1;
    @(negedge clk);
    samp = cyc; start = 1'b0; deg = 1'b1;
    exp_cnt = exp_cnt + 8'd1;
    exp_q.push_back({32'sd23, samp + 3, exp_cnt, 32'sd1});
    get_obs(30, o, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL lin_done: got none expected one done pulse"); end
    else begin
      if (o.res !== e.res) begin n_err++; $display("FAIL lin_result: got %0d expected %0d", o.res, e.res); end
      n_cmp++; if (o.cyc !== e.cyc) begin n_err++; $display("FAIL lin_latency: got %0d expected %0d", o.cyc - samp, e.cyc - samp); end
      n_cmp++; if (o.cnt !== e.cnt) begin n_err++; $display("FAIL lin_op_cnt: got %0d expected %0d", o.cnt, e.cnt); end
      n_cmp++; if (o.muls !== e.muls) begin n_err++; $display("FAIL lin_muls: got %0d expected %0d", o.muls, e.muls); end
    end
  endtask

  task automatic test_ignore_start();
    obs_t o; exp_t e; bit ok; int samp;
    @(negedge clk);
    x_in = 3; a_in = 1; b_in = 2; c_in = 3; deg = 1'b1; start = 1'b1;
    @(negedge clk);
    samp = cyc; start = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    exp_q.push_back({32'sd18, samp + 5, exp_cnt, 32'sd2});
    @(negedge clk); start = 1'b1; deg = 1'b0;   // MUL1
    @(negedge clk); start = 1'b0;               // ADD1
    @(negedge clk);                             // MUL2
    @(negedge clk); start = 1'b1;               // ADD2
    @(negedge clk); start = 1'b0;               // DONE
    get_obs(30, o, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL ign_done: got none expected one done pulse"); end
    else begin
      if (o.res !== e.res) begin n_err++; $display("FAIL ign_result: got %0d expected %0d", o.res, e.res); end
      n_cmp++; if (o.cyc !== e.cyc) begin n_err++; $display("FAIL ign_latency: got %0d expected %0d", o.cyc - samp, e.cyc - samp); end
      n_cmp++; if (o.cnt !== e.cnt) begin n_err++; $display("FAIL ign_op_cnt: got %0d expected %0d", o.cnt, e.cnt); end
      n_cmp++; if (o.muls !== e.muls) begin n_err++; $display("FAIL ign_muls: got %0d expected %0d", o.muls, e.muls); end
    end
    repeat (10) @(negedge clk);
    n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL ign_extra_done: got %0d expected 0", obs_q.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_busy: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    obs_t o; exp_t e; bit ok; int e0; int zeros;
    zeros = 0;
    @(negedge clk);
    x_in = 4; a_in = 5; b_in = 6; deg = 1'b0; start = 1'b1;
    @(negedge clk);
    e0 = cyc;
    for (int k = 0; k < 256; k++) begin
      exp_cnt = exp_cnt + 8'd1;
      exp_q.push_back({32'sd26, e0 + 3 + 5 * k, exp_cnt, 32'sd1});
      get_obs(30, o, ok);
      e = exp_q.pop_front();
      n_cmp++;
      if (!ok) begin
        n_err++; $display("FAIL b2b_done: run %0d got none expected one done pulse", k);
        break;
      end
      if (o.res !== e.res) begin n_err++; $display("FAIL b2b_result: run %0d got %0d expected %0d", k, o.res, e.res); end
      n_cmp++; if (o.cyc !== e.cyc) begin n_err++; $display("FAIL b2b_timing: run %0d got cycle %0d expected %0d", k, o.cyc, e.cyc); end
      n_cmp++; if (o.cnt !== e.cnt) begin n_err++; $display("FAIL b2b_op_cnt: run %0d got %0d expected %0d", k, o.cnt, e.cnt); end
      n_cmp++; if (o.done2 !== 1'b0) begin n_err++; $display("FAIL b2b_pulse: run %0d got %b expected 0", k, o.done2); end
      if (o.cnt == 8'd0) zeros++;
      if (k == 254) begin
        @(negedge clk);
        start = 1'b0;
      end
    end
    start = 1'b0;
    n_cmp++; if (zeros !== 1) begin n_err++; $display("FAIL b2b_wrap: got %0d wraps expected 1", zeros); end
    repeat (10) @(negedge clk);
    n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL b2b_extra_done: got %0d expected 0", obs_q.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    obs_t o; exp_t e; bit ok; int samp;
    @(negedge clk);
    x_in = 2; a_in = 3; b_in = 4; c_in = 5; deg = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({H, M1} !== 3'b101) begin n_err++; $display("FAIL rmid_in_mul2: got H,M1=%b expected 101", {H, M1}); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if ({busy, done, LX, LS, H} !== 5'b0) begin n_err++; $display("FAIL rmid_ctrl: got %b expected 00000", {busy, done, LX, LS, H}); end
    n_cmp++; if ({M0, M1, M2} !== 6'b0) begin n_err++; $display("FAIL rmid_mux: got %b expected 000000", {M0, M1, M2}); end
    n_cmp++; if (op_cnt !== 8'd0) begin n_err++; $display("FAIL rmid_op_cnt: got %0d expected 0", op_cnt); end
    repeat (8) @(negedge clk);
    n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL rmid_no_done: got %0d expected 0", obs_q.size()); end
    rst = 1'b1;
    exp_cnt = 8'd0;
    @(negedge clk);
    x_in = 5; a_in = 3; b_in = 1; deg = 1'b0; start = 1'b1;
    @(negedge clk);
    samp = cyc; start = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    exp_q.push_back({32'sd16, samp + 3, exp_cnt, 32'sd1});
    get_obs(30, o, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rmid_rerun_done: got none expected one done pulse"); end
    else begin
      if (o.res !== e.res) begin n_err++; $display("FAIL rmid_rerun_result: got %0d expected %0d", o.res, e.res); end
      n_cmp++; if (o.cyc !== e.cyc) begin n_err++; $display("FAIL rmid_rerun_latency: got %0d expected %0d", o.cyc - samp, e.cyc - samp); end
      n_cmp++; if (o.cnt !== e.cnt) begin n_err++; $display("FAIL rmid_rerun_op_cnt: got %0d expected %0d", o.cnt, e.cnt); end
    end
  endtask

`ifdef POLY_CTRL_ABORT_EN
  task automatic test_abort();
    @(negedge clk);
    x_in = 2; a_in = 3; b_in = 4; c_in = 5; deg = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);                  // MUL1
    @(negedge clk); abort = 1'b1;    // ADD1
    @(negedge clk); abort = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy); end
    repeat (8) @(negedge clk);
    n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL abort_no_done: got %0d expected 0", obs_q.size()); end
    n_cmp++; if (op_cnt !== exp_cnt) begin n_err++; $display("FAIL abort_op_cnt: got %0d expected %0d", op_cnt, exp_cnt); end
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_quadratic();
    test_linear();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
`ifdef POLY_CTRL_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
